// File: rtl/countdown_time_regs_pkg.sv
// Shared constants for the countdown time registers: BCD widths, field moduli,
// default prescaler length and the bit positions of each field in time_reading.
package countdown_time_regs_pkg;

  localparam int BCD_W             = 4;
  localparam int SEC_MOD           = 60;
  localparam int MIN_MOD           = 100;
  localparam int DEF_TICKS_PER_SEC = 100_000_000;

  // Bit offsets into time_reading, {m_tens, m_ones, s_tens, s_ones}
  localparam int S_ONES_LSB = 0;
  localparam int S_TENS_LSB = 4;
  localparam int M_ONES_LSB = 8;
  localparam int M_TENS_LSB = 12;
  localparam int SEC_LSB    = S_ONES_LSB;
  localparam int MIN_LSB    = M_ONES_LSB;

endpackage

// File: rtl/countdown_time_regs_if.sv
// Control/display bundle between the countdown FSM and the time registers.
interface countdown_time_regs_if;
  import countdown_time_regs_pkg::*;

  logic                 init_regs;
  logic                 count_enabled;
  logic                 inc;
  logic                 dec;
  logic                 min;
  logic [4*BCD_W-1:0]   time_reading;
  logic                 complete;
  logic                 sec_tick;

  modport master (
    output init_regs, count_enabled, inc, dec, min,
    input  time_reading, complete, sec_tick
  );

  modport slave (
    input  init_regs, count_enabled, inc, dec, min,
    output time_reading, complete, sec_tick
  );
endinterface

// File: rtl/countdown_time_regs_bcd_wrap_counter.sv
// Two-digit BCD up/down counter modulo MOD. Wraps at either end only when
// wrap_en is set; borrow_out flags a decrement requested while at zero.
module countdown_time_regs_bcd_wrap_counter
  import countdown_time_regs_pkg::*;
#(
  parameter int MOD = SEC_MOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  input  logic               wrap_en,
  output logic [2*BCD_W-1:0] value,
  output logic               is_zero,
  output logic               borrow_out
);

  localparam logic [BCD_W-1:0] TOP_TENS = BCD_W'((MOD - 1) / 10);
  localparam logic [BCD_W-1:0] TOP_ONES = BCD_W'((MOD - 1) % 10);

  logic [BCD_W-1:0] tens, ones;
  logic             at_top, up, dn;

  assign up         = inc & ~dec;
  assign dn         = dec & ~inc;
  assign at_top     = (tens == TOP_TENS) && (ones == TOP_ONES);
  assign is_zero    = (tens == '0) && (ones == '0);
  // Raised regardless of wrap_en so the consumer can chain it into the next field
  assign borrow_out = dn & is_zero;
  assign value      = {tens, ones};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (up) begin
      if (at_top) begin
        if (wrap_en) begin
          tens <= '0;
          ones <= '0;
        end
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (dn) begin
      if (is_zero) begin
        if (wrap_en) begin
          tens <= TOP_TENS;
          ones <= TOP_ONES;
        end
      end else if (ones == '0) begin
        tens <= tens - 4'd1;
        ones <= 4'd9;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_time_regs.sv
// mm:ss time registers with a 1 s prescaler: counts down while enabled,
// accepts per-field edits while paused, and decodes 00:00 as complete.
module countdown_time_regs
  import countdown_time_regs_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic                 clk,
  input  logic                 reset,
  countdown_time_regs_if.slave bus
);

  localparam int            PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]      presc;
  logic               counting, editing, wrap, tick_q;
  logic [2*BCD_W-1:0] sec_val, min_val;
  logic               sec_zero, min_zero, sec_borrow, min_borrow;
  logic               sec_inc, sec_dec, sec_wrap_en;
  logic               min_inc, min_dec;

  assign counting = ~bus.init_regs & bus.count_enabled;
  assign editing  = ~bus.init_regs & ~bus.count_enabled;
  assign wrap     = counting && (presc == TERM);

  // Prescaler only advances while counting, so a pause keeps the partial second
  always_ff @(posedge clk) begin
    if (reset || bus.init_regs) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (counting) presc <= wrap ? '0 : presc + 1'b1;
    end
  end

  assign sec_inc = editing & bus.inc & ~bus.min;
  assign sec_dec = (editing & bus.dec & ~bus.min) | wrap;
  assign min_inc = editing & bus.inc & bus.min;
  assign min_dec = (editing & bus.dec & bus.min) | (counting & sec_borrow);
  // At 00:00 the minutes refuse the borrow, and seconds then must not wrap to 59
  assign sec_wrap_en = ~(counting & min_borrow);

  countdown_time_regs_bcd_wrap_counter #(.MOD(SEC_MOD)) u_sec_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (bus.init_regs),
    .inc        (sec_inc),
    .dec        (sec_dec),
    .wrap_en    (sec_wrap_en),
    .value      (sec_val),
    .is_zero    (sec_zero),
    .borrow_out (sec_borrow)
  );

  countdown_time_regs_bcd_wrap_counter #(.MOD(MIN_MOD)) u_min_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (bus.init_regs),
    .inc        (min_inc),
    .dec        (min_dec),
    .wrap_en    (editing),
    .value      (min_val),
    .is_zero    (min_zero),
    .borrow_out (min_borrow)
  );

  assign bus.time_reading[SEC_LSB +: 2*BCD_W] = sec_val;
  assign bus.time_reading[MIN_LSB +: 2*BCD_W] = min_val;
  assign bus.complete = sec_zero & min_zero;
  assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_countdown_time_regs.sv
// Scoreboard bench: stimulus pushes expectations from a seconds-total model,
// a monitor pops one per clock and compares against the DUT outputs.
module tb_countdown_time_regs;
  import countdown_time_regs_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  countdown_time_regs_if bus();

  countdown_time_regs #(.TICKS_PER_SEC(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] tr;
    logic        cpl;
    logic        tick;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: minutes, seconds, fractional-second phase
  int   mm = 0, ss = 0, ph = 0;
  logic tk = 1'b0;

  function automatic logic [15:0] to_bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step(input bit r, input bit ini, input bit ce,
                      input bit i, input bit d, input bit mn);
    exp_t e;
    int   tot;
    @(negedge clk);
    reset = r; bus.init_regs = ini; bus.count_enabled = ce;
    bus.inc = i; bus.dec = d; bus.min = mn;
    if (r || ini) begin
      mm = 0; ss = 0; ph = 0; tk = 1'b0;
    end else if (ce) begin
      tk = (ph == T - 1);
      ph = tk ? 0 : ph + 1;
      tot = mm * 60 + ss;
      if (tk && tot > 0) begin
        tot = tot - 1;
        mm  = tot / 60;
        ss  = tot % 60;
      end
    end else begin
      tk = 1'b0;
      if (i && !d) begin
        if (mn) mm = (mm + 1) % 100;
        else    ss = (ss + 1) % 60;
      end else if (d && !i) begin
        if (mn) mm = (mm + 99) % 100;
        else    ss = (ss + 59) % 60;
      end
    end
    e.tr   = to_bcd(mm, ss);
    e.cpl  = (mm == 0 && ss == 0);
    e.tick = tk;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit ce);
    for (int k = 0; k < n; k++) step(0, 0, ce, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("time_reading", bus.time_reading, e.tr);
        chk("complete", {15'd0, bus.complete}, {15'd0, e.cpl});
        chk("sec_tick", {15'd0, bus.sec_tick}, {15'd0, e.tick});
      end
    end
  end

  initial begin
    bit rce;
    int wait_cyc;
    bus.init_regs = 0; bus.count_enabled = 0;
    bus.inc = 0; bus.dec = 0; bus.min = 0;

    // Reset, then quiet idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(10, 0);

    // Seconds field wrap in both directions
    repeat (3) step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);

    // Minutes field wrap and BCD carry 09 -> 10
    step(0, 0, 0, 0, 1, 1);
    repeat (11) step(0, 0, 0, 1, 0, 1);

    // Countdown 01:00 down to 00:00 and hold there
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    idle(60 * T + 12, 1);

    // Pause mid-second with an edit, then resume
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0, 0);
    idle(2, 1);
    idle(4, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(5, 0);
    idle(2 * T + 2, 1);

    // Priority: init beats count and inc; inc&dec together is a no-op
    repeat (12) step(0, 0, 0, 1, 0, 1);
    repeat (34) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    idle(T + 1, 1);
    repeat (3) step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0);

    // Count dropping exactly on the terminal cycle
    idle(T - 1, 1);
    step(0, 0, 1, 0, 0, 0);
    idle(2, 0);

    // Randomised traffic
    rce = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) rce = ~rce;
      step($urandom_range(199) == 0, $urandom_range(79) == 0, rce,
           $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1);
    end
    idle(2, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_time_regs.md
Name: countdown_time_regs

Overview:
- Datapath and time-register block driven by the countdown control FSM. It consumes init_regs, count_enabled, inc, dec and min, and returns complete.
- Holds the mm:ss value as four BCD digits and derives a 1 s tick from the system clock with a prescaler.
- Decrements the value once per second while counting and applies minute/second edits while paused.
- Feeds the 7-segment display driver through time_reading.

Parameters:
- TICKS_PER_SEC, 100_000_000: clk cycles per second. Simulation uses small values, e.g. 4.
- MAX_MIN, 99: largest minutes value. Fixed at 99 for this block: the minutes range is 00..99 and wraps modulo 100.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high.
- init_regs  input  1  level; clear time and prescaler.
- count_enabled  input  1  level; count down at 1 Hz.
- inc  input  1  single-cycle pulse; +1 to the selected field.
- dec  input  1  single-cycle pulse; -1 to the selected field.
- min  input  1  field select: 1 = minutes, 0 = seconds.
- time_reading  output  16  BCD {m_tens, m_ones, s_tens, s_ones}.
- complete  output  1  high when the time equals 00:00.
- sec_tick  output  1  one-cycle strobe when a second elapses; used by the display blink logic.

Behaviour:
- Clock and reset: already decided — reset is synchronous, active-high; clock is clk.
- Reset values:
  - time_reading = 16'h0000.
  - Prescaler = 0.
  - sec_tick = 0.
  - complete = 1, since it decodes 00:00.
- complete: combinational decode, (time_reading == 16'h0000). Zero latency, because the control FSM gates count_enabled with it in the same cycle.
- Per-cycle priority: reset > init_regs > count_enabled > inc/dec.
- init_regs = 1: next cycle, time = 00:00 and prescaler = 0. inc and dec are ignored.
- count_enabled = 1:
  - Prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and sec_tick pulses high for that cycle, registered one cycle after the terminal count.
  - On each wrap the time decrements by 1 s:
    - s_ones 1..9 → s_ones - 1.
    - s_ones 0 with s_tens > 0 → s_tens - 1, s_ones = 9.
    - ss = 00 with mm > 0 → ss = 59, mm - 1 (BCD borrow across minute digits).
    - Time already 00:00 → no change. No wrap to 99:59, ever.
  - inc and dec are ignored while count_enabled = 1.
- count_enabled = 0: prescaler holds its value, so pause/resume preserves the fractional second. sec_tick = 0.
- Edits apply only when init_regs = 0 and count_enabled = 0. Every result stays valid BCD.
  - inc & ~dec, min = 1: mm = (mm + 1) mod 100, so 99 → 00.
  - inc & ~dec, min = 0: ss = (ss + 1) mod 60, so 59 → 00. No carry into minutes.
  - dec & ~inc, min = 1: 00 → 99.
  - dec & ~inc, min = 0: 00 → 59. No borrow from minutes.
  - inc & dec together: no change.
  - Inc/dec held high for N cycles: N steps. Debouncing and one-pulse shaping are upstream.
- Reset or init_regs mid-count: takes effect next cycle and clears the prescaler, so there is no stale partial second.
- count_enabled falling on the same cycle as the prescaler terminal count: the decrement and tick still occur for that cycle.
- No other state; the block has no FSM of its own beyond the prescaler.

Decomposition:
- Shared package or header holds:
  - BCD digit width (4).
  - SEC_MOD = 60.
  - MIN_MOD = 100.
  - Default TICKS_PER_SEC.
  - Field index constants for the time_reading slices.
- One sub-module, bcd_wrap_counter:
  - Two-digit BCD counter; parameter MOD (60 or 100).
  - Inputs: clr, inc, dec, wrap_en.
  - Outputs: value[7:0], is_zero, borrow_out.
  - Instantiated once for seconds and once for minutes. For countdown the seconds borrow_out drives the minutes dec; edit mode uses wrap_en = 1.
- Prescaler and priority muxing stay in countdown_time_regs.

Test Plan (TICKS_PER_SEC = 4 unless noted):
- Reset check: reset high 2 cycles → time_reading = 16'h0000, complete = 1, sec_tick = 0. Then 10 idle cycles → no change.
- Second-field wrap: min = 0, three dec pulses from 00:00 → 00:59, 00:58, 00:57. Two inc pulses from 00:58 → 00:59, then 00:00 with mm unchanged.
- Minute-field wrap and BCD: min = 1, dec from 00:00 → 99:00. Then 11 inc pulses → 10:00; verify 09 → 10 BCD carry.
- Countdown with borrow: load 01:00 and hold count_enabled → after 4 cycles 00:59 with sec_tick pulse. Continue to 00:00 → complete = 1, value holds at 00:00 with count_enabled still high.
- Pause preserves phase: count 2 cycles, drop count_enabled 10 cycles (apply an inc, min = 0, so 00:05 → 00:06), re-enable → decrement occurs after exactly 2 more cycles.
- Priority: init_regs asserted with count_enabled and inc high at 12:34 → next cycle 00:00, prescaler 0. inc & dec together while paused → value unchanged.
